// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: accumulates keypad digits into a BCD shift register,
// supports clear/backspace/enter, converts the BCD entry to binary one digit
// per cycle, and holds the result under a valid/ack handshake.
module digit_entry_buffer #(
  parameter int NDIGITS = 4,
  parameter int BINW    = 14,
  parameter int CNTW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 keystrobe,
  input  logic [3:0]           keycode,
  input  logic                 ack,
  output logic [4*NDIGITS-1:0] digits,
  output logic [CNTW-1:0]      count,
  output logic                 isdig,
  output logic                 overflow,
  output logic                 busy,
  output logic                 valid,
  output logic [BINW-1:0]      value
);

  localparam int DW = 4 * NDIGITS;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CONV  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ks_q;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] step_q, step_d;
  logic [BINW-1:0] acc_q, acc_d;
  logic [BINW-1:0] value_q, value_d;
  logic            isdig_q, isdig_d;
  logic            overflow_q, overflow_d;

  logic            press;
  logic [3:0]      conv_digit;
  logic [BINW-1:0] mac;

  // A press is the first cycle of a strobe; long strobes act only once.
  assign press = keystrobe & ~ks_q;

  // Pick the digit for this conversion step, most significant position first.
  always_comb begin
    conv_digit = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (step_q == CNTW'(NDIGITS - 1 - i)) begin
        conv_digit = digits_q[4*i +: 4];
      end
    end
    mac = acc_q * BINW'(10) + BINW'(conv_digit);
  end

  // Next-state and datapath updates for entry, conversion and hand-off.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    count_d    = count_q;
    step_d     = step_q;
    acc_d      = acc_q;
    value_d    = value_q;
    isdig_d    = 1'b0;
    overflow_d = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (press) begin
          if (keycode < 4'd10) begin
            if (count_q < CNTW'(NDIGITS)) begin
              digits_d = (digits_q << 4) | DW'(keycode);
              count_d  = count_q + CNTW'(1);
              isdig_d  = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            case (keycode)
              4'hA: begin
                digits_d = '0;
                count_d  = '0;
              end
              4'hB: begin
                if (count_q != '0) begin
                  digits_d = digits_q >> 4;
                  count_d  = count_q - CNTW'(1);
                end
              end
              4'hC: begin
                if (count_q != '0) begin
                  state_d = ST_CONV;
                  acc_d   = '0;
                  step_d  = '0;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_CONV: begin
        acc_d  = mac;
        step_d = step_q + CNTW'(1);
        if (step_q == CNTW'(NDIGITS - 1)) begin
          value_d = mac;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d  = ST_ENTRY;
          digits_d = '0;
          count_d  = '0;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // State register; reset discards any partial conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      ks_q       <= 1'b0;
      digits_q   <= '0;
      count_q    <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      value_q    <= '0;
      isdig_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ks_q       <= keystrobe;
      digits_q   <= digits_d;
      count_q    <= count_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      value_q    <= value_d;
      isdig_q    <= isdig_d;
      overflow_q <= overflow_d;
    end
  end

  assign digits   = digits_q;
  assign count    = count_q;
  assign isdig    = isdig_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_ENTRY);
  assign valid    = (state_q == ST_DONE);
  assign value    = value_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: table-driven key sequences, hand-written
// conversion/reset corner cases, and random stimulus against a queue model.
module tb_digit_entry_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        keystrobe = 1'b0;
  logic [3:0]  keycode = 4'd0;
  logic        ack = 1'b0;
  logic [15:0] digits, digits13;
  logic [2:0]  count, count13;
  logic        isdig, overflow, busy, valid;
  logic        isdig13, overflow13, busy13, valid13;
  logic [13:0] value;
  logic [12:0] value13;

  always #5 clk = ~clk;

  digit_entry_buffer #(.NDIGITS(4), .BINW(14), .CNTW(3)) dut (
    .clk(clk), .rst(rst), .keystrobe(keystrobe), .keycode(keycode), .ack(ack),
    .digits(digits), .count(count), .isdig(isdig), .overflow(overflow),
    .busy(busy), .valid(valid), .value(value));

  digit_entry_buffer #(.NDIGITS(4), .BINW(13), .CNTW(3)) dut13 (
    .clk(clk), .rst(rst), .keystrobe(keystrobe), .keycode(keycode), .ack(ack),
    .digits(digits13), .count(count13), .isdig(isdig13), .overflow(overflow13),
    .busy(busy13), .valid(valid13), .value(value13));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entered digits as a queue (oldest first), a conversion
  // countdown, and a holding flag while the result awaits ack.
  int          m_q[$];
  bit          m_ks, m_isdig, m_ovf, m_hold, m_pr;
  int          m_left;
  int          m_value, m_value13;

  function automatic int dec_value(input int w);
    int v = 0;
    foreach (m_q[i]) v = (v * 10 + m_q[i]) % (1 << w);
    return v;
  endfunction

  function automatic logic [15:0] packed_digits();
    logic [15:0] d = 16'h0;
    foreach (m_q[i]) d = (d << 4) | 16'(m_q[i]);
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ks = 0; m_isdig = 0; m_ovf = 0; m_hold = 0; m_left = 0;
      m_value = 0; m_value13 = 0;
    end else begin
      m_pr = keystrobe && !m_ks;
      m_ks = keystrobe;
      m_isdig = 0;
      m_ovf = 0;
      if (m_hold) begin
        if (ack) begin
          m_hold = 0;
          m_q.delete();
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_value = dec_value(14);
          m_value13 = dec_value(13);
          m_hold = 1;
        end
      end else if (m_pr) begin
        if (keycode < 10) begin
          if (m_q.size() < 4) begin
            m_q.push_back(int'(keycode));
            m_isdig = 1;
          end else m_ovf = 1;
        end else if (keycode == 4'hA) m_q.delete();
        else if (keycode == 4'hB) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (keycode == 4'hC && m_q.size() > 0) m_left = 4;
      end
    end
  end

  bit chk_en = 0;
  int iscnt = 0;

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (isdig) iscnt++;
    if (chk_en && !rst) begin
      chk("m_digits", digits, packed_digits());
      chk("m_count", count, m_q.size());
      chk("m_isdig", isdig, m_isdig);
      chk("m_overflow", overflow, m_ovf);
      chk("m_busy", busy, m_hold || (m_left > 0));
      chk("m_valid", valid, m_hold);
      chk("m_value", value, m_value);
      chk("m_value13", value13, m_value13);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic s_isdig, s_ovf;
  task automatic press(input logic [3:0] code, input int hold, input int gap);
    keycode = code;
    keystrobe = 1'b1;
    step();
    s_isdig = isdig;
    s_ovf = overflow;
    $display("key %h -> digits=%h count=%0d isdig=%0b ovf=%0b", code, digits, count, isdig, overflow);
    repeat (hold - 1) step();
    keystrobe = 1'b0;
    repeat (gap) step();
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [15:0] exp_digits;
    int          exp_count;
    bit          exp_isdig;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{4'h1, 16'h0001, 1, 1, 0};
    tbl[1]  = '{4'h2, 16'h0012, 2, 1, 0};
    tbl[2]  = '{4'h3, 16'h0123, 3, 1, 0};
    tbl[3]  = '{4'h4, 16'h1234, 4, 1, 0};
    tbl[4]  = '{4'h5, 16'h1234, 4, 0, 1};
    tbl[5]  = '{4'hB, 16'h0123, 3, 0, 0};
    tbl[6]  = '{4'hB, 16'h0012, 2, 0, 0};
    tbl[7]  = '{4'hB, 16'h0001, 1, 0, 0};
    tbl[8]  = '{4'hB, 16'h0000, 0, 0, 0};
    tbl[9]  = '{4'hB, 16'h0000, 0, 0, 0};
    tbl[10] = '{4'hD, 16'h0000, 0, 0, 0};
    tbl[11] = '{4'h0, 16'h0000, 1, 1, 0};
    tbl[12] = '{4'h4, 16'h0004, 2, 1, 0};
    tbl[13] = '{4'hA, 16'h0000, 0, 0, 0};
    tbl[14] = '{4'hC, 16'h0000, 0, 0, 0};

    repeat (2) step();
    chk("rst_digits", digits, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_value", value, 0);
    rst = 1'b0;
    step();
    chk_en = 1;
    iscnt = 0;

    for (int i = 0; i < 15; i++) begin
      press(tbl[i].code, 3, 2);
      chk("tbl_isdig", s_isdig, tbl[i].exp_isdig);
      chk("tbl_ovf", s_ovf, tbl[i].exp_ovf);
      chk("tbl_digits", digits, tbl[i].exp_digits);
      chk("tbl_count", count, tbl[i].exp_count);
      chk("tbl_busy", busy, 0);
      if (i == 3) chk("isdig_pulses", iscnt, 4);
    end

    // Enter 042: busy after edge k, valid after edge k+4, presses ignored.
    press(4'h0, 3, 2);
    press(4'h4, 3, 2);
    press(4'h2, 3, 2);
    keycode = 4'hC; keystrobe = 1'b1;
    step();                                   // edge k
    chk("enter_busy", busy, 1);
    chk("enter_valid", valid, 0);
    keystrobe = 1'b0;
    step();                                   // k+1
    chk("conv1_valid", valid, 0);
    keycode = 4'h7; keystrobe = 1'b1;
    step();                                   // k+2, press ignored
    chk("conv_press_isdig", isdig, 0);
    chk("conv_press_digits", digits, 16'h0042);
    keystrobe = 1'b0;
    step();                                   // k+3
    chk("conv3_valid", valid, 0);
    step();                                   // k+4
    chk("done_valid", valid, 1);
    chk("done_value", value, 42);
    for (int i = 0; i < 10; i++) begin
      keystrobe = (i == 4);
      step();
      chk("hold_value", value, 42);
      chk("hold_valid", valid, 1);
      chk("hold_digits", digits, 16'h0042);
    end
    keystrobe = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_count", count, 0);
    chk("ack_digits", digits, 0);
    step();

    // 9999 and its 13-bit wrap; press concurrent with ack is ignored.
    repeat (4) press(4'h9, 2, 1);
    press(4'hC, 1, 4);
    chk("v9999", value, 9999);
    chk("v9999_w13", value13, 1807);
    keycode = 4'h3; keystrobe = 1'b1; ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ackpress_count", count, 0);
    chk("ackpress_isdig", isdig, 0);
    chk("ackpress_valid", valid, 0);
    keystrobe = 1'b0;
    step();
    chk("ackpress_after_isdig", isdig, 0);

    // Reset two cycles into conversion.
    press(4'h5, 1, 1);                        // edge k-? digit 5
    press(4'hC, 1, 1);                        // now at k+1
    step();                                   // k+2
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_digits", digits, 0);
    chk("midrst_count", count, 0);
    chk("midrst_value", value, 0);
    step();
    rst = 1'b0;
    step();
    press(4'h7, 3, 2);
    chk("postrst_isdig", s_isdig, 1);
    chk("postrst_digits", digits, 16'h0007);
    chk("postrst_count", count, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] k;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) keystrobe = ~keystrobe;
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) k = 4'hC;
      keycode = k;
      ack = ($urandom_range(0, 5) == 0);
      step();
    end
    rst = 1'b0;
    keystrobe = 1'b0;
    ack = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
